// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU memory / I/O bridge: window base, register
// offsets, STATUS bit positions and the address decode helper.
package mem_io_pkg;

  localparam logic [12:0] IO_BASE = 13'h1FF0;

  localparam logic [3:0] OFS_TXDATA = 4'd0;
  localparam logic [3:0] OFS_STATUS = 4'd1;
  localparam logic [3:0] OFS_SWITCH = 4'd2;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 2;
  localparam int STAT_CNT_W   = 3;
  localparam int STAT_OVF     = 15;

  typedef enum logic [1:0] {
    REG_TXDATA,
    REG_STATUS,
    REG_SWITCH,
    REG_NONE
  } io_reg_e;

  // The I/O window is 16 words; only the upper nine address bits select it.
  function automatic logic is_io(input logic [12:0] addr, input logic [12:0] base);
    return addr[12:4] == base[12:4];
  endfunction

  function automatic io_reg_e decode_reg(input logic [3:0] offset);
    case (offset)
      OFS_TXDATA: return REG_TXDATA;
      OFS_STATUS: return REG_STATUS;
      OFS_SWITCH: return REG_SWITCH;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Transmit FIFO with combinational head output; pointers wrap modulo DEPTH.
// Storage is not reset, only the pointers and occupancy count.
module io_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign rdata = mem_reg[rd_ptr_reg];

  // When full, a same-cycle pop frees the head slot that wr_ptr points at.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-side bridge: routes word accesses to block RAM or a 16-word I/O window
// holding a TX FIFO, a STATUS register and synchronized switch inputs.
module mem_io_bridge #(
  parameter logic [12:0] IO_BASE    = mem_io_pkg::IO_BASE,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] addr_toRAM,
  input  logic [15:0] data_toRAM,
  input  logic        wrEn,
  output logic [15:0] data_fromRAM,
  output logic [12:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] sw_in
);

  import mem_io_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             io_sel;
  io_reg_e          io_reg;
  logic             tx_wr;
  logic             status_rd;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             ovf_set;
  logic [15:0]      status_word;
  logic [15:0]      io_rdata_next;

  logic             sel_reg;
  logic [15:0]      io_rdata_reg;
  logic             ovf_reg;
  logic [15:0]      sw_meta_reg;
  logic [15:0]      sw_sync_reg;

  assign io_sel = is_io(addr_toRAM, IO_BASE);
  assign io_reg = decode_reg(addr_toRAM[3:0]);

  assign ram_addr  = addr_toRAM;
  assign ram_wdata = data_toRAM;
  assign ram_we    = wrEn & ~io_sel;

  assign tx_wr     = io_sel & wrEn & (io_reg == REG_TXDATA);
  assign status_rd = io_sel & ~wrEn & (io_reg == REG_STATUS);

  assign out_valid = ~fifo_empty;
  assign fifo_pop  = out_valid & out_ready;
  assign fifo_push = tx_wr & (~fifo_full | fifo_pop);
  assign ovf_set   = tx_wr & fifo_full & ~fifo_pop;

  io_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (data_toRAM),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    status_word[STAT_OVF]   = ovf_reg;
  end

  always_comb begin
    io_rdata_next = '0;
    case (io_reg)
      REG_STATUS: io_rdata_next = status_word;
      REG_SWITCH: io_rdata_next = sw_sync_reg;
      default:    io_rdata_next = '0;
    endcase
  end

  // STATUS is captured into io_rdata_reg before overflow clears; a new
  // overflow in the same cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg      <= 1'b0;
      io_rdata_reg <= '0;
      ovf_reg      <= 1'b0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
    end else begin
      sel_reg      <= io_sel;
      io_rdata_reg <= io_rdata_next;
      sw_meta_reg  <= sw_in;
      sw_sync_reg  <= sw_meta_reg;
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (status_rd) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign data_fromRAM = sel_reg ? io_rdata_reg : ram_rdata;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: stimulus pushes expected read data and
// stream words into queues; monitors pop and compare on the falling edge.
module tb_mem_io_bridge;

  logic        clk;
  logic        rst_n;
  logic [12:0] addr_toRAM;
  logic [15:0] data_toRAM;
  logic        wrEn;
  logic [15:0] data_fromRAM;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sw_in;

  int vectors;
  int miscompares;

  logic [15:0] rd_q[$];
  logic [15:0] tx_q[$];
  logic        rd_flag;
  logic        rd_pending;
  logic        hold_pending;
  logic [15:0] held_data;

  logic [15:0] ram_mem [8192];

  mem_io_bridge #(
    .IO_BASE    (13'h1FF0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .wrEn         (wrEn),
    .data_fromRAM (data_fromRAM),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sw_in        (sw_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model with one-cycle registered read.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%04h", name, act);
    end
  endfunction

  // Read-data monitor: a read issued in one cycle is checked one cycle later.
  initial begin
    rd_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_pending) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", data_fromRAM, 16'hxxxx);
        end else begin
          chk("rd_data", data_fromRAM, rd_q.pop_front());
        end
      end
      rd_pending = rd_flag;
    end
  end

  // Stream monitor: compares accepted words and checks stall stability.
  initial begin
    hold_pending = 1'b0;
    held_data    = '0;
    forever begin
      @(negedge clk);
      if (hold_pending && out_valid) chk("tx_hold", out_data, held_data);
      if (out_valid && out_ready) begin
        if (tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got 0x%04h expected none", out_data);
        end else begin
          chk("tx_data", out_data, tx_q.pop_front());
        end
      end
      hold_pending = out_valid && !out_ready;
      held_data    = out_data;
    end
  end

  task automatic cpu_write(input logic [12:0] a, input logic [15:0] d, input logic exp_we);
    @(posedge clk); #1;
    addr_toRAM = a; data_toRAM = d; wrEn = 1'b1; rd_flag = 1'b0;
    #1 chk("ram_we", {15'd0, ram_we}, {15'd0, exp_we});
  endtask

  task automatic cpu_read(input logic [12:0] a, input logic [15:0] exp);
    @(posedge clk); #1;
    addr_toRAM = a; wrEn = 1'b0; rd_flag = 1'b1;
    rd_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      addr_toRAM = 13'h0100; wrEn = 1'b0; rd_flag = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    while (out_valid && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk(name, {15'd0, out_valid}, 16'h0000);
    out_ready = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; addr_toRAM = 13'h0100; data_toRAM = '0; wrEn = 1'b0;
    out_ready = 1'b0; sw_in = '0; rd_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_out_valid", {15'd0, out_valid}, 16'h0000);
    rst_n = 1'b1;

    // Reset state and RAM path
    cpu_read(13'h1FF1, 16'h0001);
    cpu_write(13'h0005, 16'h1234, 1'b1);
    cpu_read(13'h0005, 16'h1234);
    idle(2);

    // TX path: two words, stall, then stream
    cpu_write(13'h1FF0, 16'hAAAA, 1'b0); tx_q.push_back(16'hAAAA);
    cpu_write(13'h1FF0, 16'hBBBB, 1'b0); tx_q.push_back(16'hBBBB);
    cpu_read(13'h1FF1, 16'h0008);
    idle(2);
    drain("tx_drain_empty");

    // Overflow: fifth write dropped, STATUS clears overflow on read
    for (int i = 1; i <= 5; i++) begin
      cpu_write(13'h1FF0, 16'(i), 1'b0);
      if (i <= 4) tx_q.push_back(16'(i));
    end
    cpu_read(13'h1FF1, 16'h8012);
    cpu_read(13'h1FF1, 16'h0012);
    idle(1);
    drain("ovf_drain_empty");

    // Full FIFO: push and pop in the same cycle
    cpu_write(13'h1FF0, 16'h0010, 1'b0); tx_q.push_back(16'h0010);
    cpu_write(13'h1FF0, 16'h0020, 1'b0); tx_q.push_back(16'h0020);
    cpu_write(13'h1FF0, 16'h0030, 1'b0); tx_q.push_back(16'h0030);
    cpu_write(13'h1FF0, 16'h0040, 1'b0); tx_q.push_back(16'h0040);
    tx_q.push_back(16'h5555);
    @(posedge clk); #1;
    addr_toRAM = 13'h1FF0; data_toRAM = 16'h5555; wrEn = 1'b1; rd_flag = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; addr_toRAM = 13'h1FF1; wrEn = 1'b0; rd_flag = 1'b1;
    rd_q.push_back(16'h0012);
    idle(1);
    drain("full_pp_drain_empty");

    // Switch synchronizer and unused offsets
    sw_in = 16'h00F0;
    idle(3);
    cpu_read(13'h1FF2, 16'h00F0);
    cpu_read(13'h1FF7, 16'h0000);
    cpu_write(13'h1FF7, 16'hDEAD, 1'b0);
    cpu_read(13'h1FF1, 16'h0001);
    idle(2);

    // Reset mid-stream discards the FIFO
    cpu_write(13'h1FF0, 16'h0101, 1'b0);
    cpu_write(13'h1FF0, 16'h0202, 1'b0);
    cpu_write(13'h1FF0, 16'h0303, 1'b0);
    idle(1);
    chk("pre_reset_valid", {15'd0, out_valid}, 16'h0001);
    #1 rst_n = 1'b0;
    #1 chk("reset_async_valid", {15'd0, out_valid}, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;
    cpu_read(13'h1FF1, 16'h0001);
    idle(3);

    chk("rd_q_left", 16'(rd_q.size()), 16'h0000);
    chk("tx_q_left", 16'(tx_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameter IO_BASE, default 13'h1FF0, first address of the 16-word I/O window (bits [3:0] of IO_BASE are zero).
REQ-002 Parameter FIFO_DEPTH, default 4, number of entries in the TX FIFO (power of two).
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port addr_toRAM  in  13  CPU word address.
REQ-006 Port data_toRAM  in  16  CPU write data.
REQ-007 Port wrEn  in  1  CPU write strobe.
REQ-008 Port data_fromRAM  out  16  read data to CPU, valid one cycle after the address.
REQ-009 Port ram_addr  out  13  block-RAM address.
REQ-010 Port ram_wdata  out  16  block-RAM write data.
REQ-011 Port ram_we  out  1  block-RAM write enable.
REQ-012 Port ram_rdata  in  16  block-RAM read data, synchronous, one-cycle latency.
REQ-013 Port out_data  out  16  TX stream data, head of FIFO.
REQ-014 Port out_valid  out  1  TX stream valid.
REQ-015 Port out_ready  in  1  TX stream consumer ready.
REQ-016 Port sw_in  in  16  asynchronous switch inputs.

Function
REQ-017 The block SHALL treat addr_toRAM[12:4] == IO_BASE[12:4] as an I/O access and all other addresses as RAM accesses.
REQ-018 RAM access: ram_addr = addr_toRAM, ram_wdata = data_toRAM, ram_we = wrEn, all combinational.
REQ-019 I/O access: ram_we SHALL be 0; ram_addr and ram_wdata still follow the CPU.
REQ-020 A registered select flag, set when the previous cycle was an I/O access, SHALL make data_fromRAM = io_rdata_q; otherwise data_fromRAM = ram_rdata.
REQ-021 io_rdata_q SHALL be registered each cycle from the I/O map below, so read latency is exactly one cycle in both regions.
REQ-022 Offset 0, TXDATA: a write pushes data_toRAM into the FIFO; a read returns 0.
REQ-023 Offset 1, STATUS (read-only) bit layout: bit0 empty, bit1 full, bits[4:2] count (0..FIFO_DEPTH), bit15 overflow, other bits 0.
REQ-024 Offset 2, SWITCH (read-only): returns sw_in after a two-flop synchronizer.
REQ-025 Offsets 3..15: reads return 0 and writes are ignored.
REQ-026 out_valid = !empty; out_data = FIFO head; out_data SHALL hold stable while out_valid && !out_ready.
REQ-027 Pop occurs when out_valid && out_ready; push occurs on a TXDATA write when the FIFO is not full, or when it is full and a pop happens in the same cycle.
REQ-028 Simultaneous push and pop SHALL leave count unchanged and keep data order.
REQ-029 Overflow: a TXDATA write while full with no pop SHALL drop the data and set the sticky overflow bit.
REQ-030 A STATUS read SHALL clear overflow after the read value is captured; if a new overflow occurs in the same cycle, set wins.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-032 rst_n low SHALL asynchronously clear FIFO pointers and count, overflow, select flag, io_rdata_q and synchronizer flops.
REQ-033 While rst_n is low: data_fromRAM = ram_rdata (select flag 0), out_valid = 0, ram_we follows the CPU.
REQ-034 Reset during operation SHALL discard all FIFO contents; no pop is reported.

Structure
REQ-035 Package mem_io_pkg SHALL hold IO_BASE, the register offsets (TXDATA=0, STATUS=1, SWITCH=2) and the STATUS bit positions.
REQ-036 The FIFO SHALL be a sub-module io_tx_fifo with push/pop/full/empty/count ports; decode, read mux and synchronizer stay in mem_io_bridge.

Verification
REQ-037 RAM path: write 0x1234 to 0x0005, then read 0x0005 -> ram_we=1 on the write cycle; data_fromRAM=0x1234 on the cycle after the read.
REQ-038 TX path: write 0xAAAA and 0xBBBB to 0x1FF0 with out_ready=0 -> STATUS reads 0x0008; after out_ready=1, the stream emits 0xAAAA then 0xBBBB, then out_valid=0.
REQ-039 Overflow: five TXDATA writes with out_ready=0 -> fifth write dropped; STATUS=0x8012; a second STATUS read=0x0012.
REQ-040 Full push+pop: FIFO full, TXDATA write of 0x5555 in the same cycle as a pop -> count stays 4, overflow stays 0, 0x5555 emerges last.
REQ-041 Switch: sw_in=0x00F0 held 3 cycles, then read 0x1FF2 -> data_fromRAM=0x00F0; read 0x1FF7 -> data_fromRAM=0.
REQ-042 Reset mid-stream: FIFO holds 3 entries, pulse rst_n low -> out_valid=0 immediately; STATUS then reads 0x0001.
